instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the CPU instruction memory: receives a length-prefixed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words, and issues single-cycle write strobes into the instruction memory array.
- Write addresses are byte addresses with bits [1:0] = 0. The memory indexes words with addr[31:2], so word k lands at array index k.
- Holds the CPU in reset while a load is in progress.

Parameters:
- ADDR_WIDTH, 16, word-index width of the instruction memory; capacity is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; fixed at 32, with 4 bytes per word.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in holds a valid byte
- byte_ready  out  1  loader can accept a byte this cycle
- we  out  1  instruction-memory write strobe, one cycle per word
- waddr  out  32  byte address of the word being written; waddr[1:0] is always 0
- wdata  out  32  assembled instruction word
- cpu_hold  out  1  holds the CPU core in reset while loading
- done  out  1  level: last load completed successfully
- err  out  1  level: last load aborted because the length exceeded capacity

Behaviour:
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_in is ignored otherwise. The producer must hold the byte until it is accepted.
- Reset (rst low, asynchronous): state=IDLE, byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, done=0, err=0. Internal len, word_idx and byte_cnt are all cleared.
- Reset asserted mid-load abandons the load immediately. Words already written stay in memory. No done or err is raised.
- States and transitions:
  - IDLE: byte_ready=0. start -> HDR, clearing byte_cnt and word_idx.
  - HDR: byte_ready=1. Accepts 4 bytes as a little-endian 32-bit word count N; the first byte is N[7:0]. On the 4th accepted byte:
    - N==0 -> DONE.
    - N > 2**ADDR_WIDTH -> ERR.
    - otherwise -> DATA.
  - DATA: byte_ready=1. Byte j (0..3) of the word is placed in bits [8j+7:8j]. On the 4th accepted byte -> WRITE.
  - WRITE: byte_ready=0; we=1 for exactly this cycle; waddr={word_idx,2'b00} zero-extended to 32 bits; wdata is the assembled word. Then word_idx increments. If the new word_idx==N -> DONE, else -> DATA.
  - DONE: done=1, err=0. start -> HDR, clearing done.
  - ERR: err=1, done=0. start -> HDR, clearing err.
- start is ignored while in HDR, DATA or WRITE.
- cpu_hold=1 exactly while in HDR, DATA or WRITE. It drops in the same cycle done or err rises.
- Latency: we asserts on the cycle immediately after the clock edge that accepted byte 3 of a word. Sustained throughput is one word per 5 cycles.
- A valid byte presented during WRITE is not accepted (byte_ready=0) and is taken on the following DATA cycle.
- Boundary: N==2**ADDR_WIDTH is legal. The final write has waddr=4*(2**ADDR_WIDTH-1) and word_idx wraps to 0 internally. Termination uses the N comparison, not the wrap.
- Outside WRITE: we=0. waddr and wdata hold their last values.

Test Plan:
- Reset mid-stream: assert rst low after 6 data bytes -> all outputs at reset values asynchronously; no we pulse follows; a fresh start loads normally.
- Basic load: start, then bytes 02 00 00 00, 13 05 A0 00, 6F 00 00 00 -> we at 0x0 with 0x00A00513, then we at 0x4 with 0x0000006F; done=1; cpu_hold low afterward.
- Empty load: header 00 00 00 00 -> DONE with no we pulse; cpu_hold high for exactly the 4 header-accept cycles.
- Oversize: ADDR_WIDTH=2, header 05 00 00 00 -> err=1, no we pulse. A subsequent start with header 04 00 00 00 and 16 bytes -> 4 writes at 0x0, 0x4, 0x8, 0xC, done=1, err=0.
- Backpressure/gaps: byte_valid toggled randomly, and valid held high during WRITE -> no byte lost or duplicated; wdata matches the reference words; exactly N we pulses.
- start while busy: pulse start in the middle of DATA -> ignored; load completes with the same addresses and data.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction-memory writer: takes a length-prefixed little-endian byte stream,
// assembles 32-bit words and pulses one write per word while holding the CPU in reset.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  we,
  output logic [31:0]           waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  state_t                state, state_nxt;
  logic [31:0]           len;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_cnt;

  logic                  accept;
  logic                  last_byte;
  logic                  idle_like;
  logic [31:0]           len_full;
  logic [ADDR_WIDTH:0]   idx_inc;

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, and the producer holds byte_in until taken.
  assign accept    = byte_valid && byte_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign len_full  = {byte_in, len[31:8]};
  // One extra bit so a full-capacity load terminates on the count, not the wrap.
  assign idx_inc   = {1'b0, word_idx} + (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    we         = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept && last_byte) begin
          if (len_full == 32'd0)                   state_nxt = S_DONE;
          else if ({1'b0, len_full} > CAPACITY)    state_nxt = S_ERR;
          else                                     state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept && last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        we       = 1'b1;
        cpu_hold = 1'b1;
        if (idx_inc == len[ADDR_WIDTH:0]) state_nxt = S_DONE;
        else                              state_nxt = S_DATA;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len      <= '0;
      word_buf <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      if (idle_like && start) begin
        byte_cnt <= '0;
        word_idx <= '0;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_HDR) len <= len_full;
        if (state == S_DATA) begin
          word_buf <= {byte_in, word_buf[DATA_WIDTH-1:8]};
          // Present the finished word and its address for the WRITE cycle.
          if (last_byte) begin
            wdata <= {byte_in, word_buf[DATA_WIDTH-1:8]};
            waddr <= 32'({word_idx, 2'b00});
          end
        end
      end
      if (state == S_WRITE) word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader with a small capacity (4 words): directed and randomized
// streams checked against a byte-stream reference model and a write scoreboard.
module tb_instr_mem_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int we_cnt      = 0;
  int hold_cnt    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  stream_q[$];
  bit          exp_done, exp_err;
  int          exp_writes;

  instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .we(we),
    .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected (addr, data)
  always @(negedge clk) begin
    if (cpu_hold === 1'b1) hold_cnt++;
    if (we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) check("we_without_expected_write", {31'd0, we}, 32'd0);
      else begin
        check("waddr", waddr, exp_addr_q.pop_front());
        check("wdata", wdata, exp_q.pop_front());
      end
    end
  end

  // reference model: interpret stream_q as header + payload
  task automatic build_model();
    longint n = 0;
    for (int i = 0; i < 4; i++) n += longint'(stream_q[i]) << (8 * i);
    exp_err    = (n > CAP);
    exp_done   = !exp_err;
    exp_writes = exp_err ? 0 : int'(n);
    for (int k = 0; k < exp_writes; k++) begin
      logic [31:0] word = 32'd0;
      for (int j = 0; j < 4; j++) word = word + stream_q[4 + 4*k + j] * (32'd1 << (8 * j));
      exp_q.push_back(word);
      exp_addr_q.push_back(32'(4 * k));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("byte_ready_before_accept", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done === 1'b1 || err === 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_stream(input bit gaps, input int busy_at);
    int base_we;
    build_model();
    base_we = we_cnt;
    pulse_start();
    for (int i = 0; i < stream_q.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (i == busy_at) pulse_start();
      send_byte(stream_q[i]);
    end
    wait_end();
    check("done", {31'd0, done}, {31'd0, exp_done});
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("cpu_hold_after", {31'd0, cpu_hold}, 32'd0);
    check("we_count", 32'(we_cnt - base_we), 32'(exp_writes));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic make_random(input int n);
    stream_q.delete();
    for (int i = 0; i < 4; i++) stream_q.push_back(8'(n >> (8 * i)));
    if (n <= CAP) for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
  endtask

  task automatic load_basic();
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00};
  endtask

  initial begin
    int base_hold, base_we;
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // basic two-word load
    load_basic();
    run_stream(1'b0, -1);

    // empty load: hold only during the 4 header bytes
    stream_q  = '{8'h00, 8'h00, 8'h00, 8'h00};
    base_hold = hold_cnt;
    run_stream(1'b0, -1);
    check("empty_hold_cycles", 32'(hold_cnt - base_hold), 32'd4);

    // oversize then full-capacity load
    stream_q = '{8'h05, 8'h00, 8'h00, 8'h00};
    run_stream(1'b0, -1);
    make_random(CAP);
    run_stream(1'b1, -1);

    // start pulsed in the middle of DATA is ignored
    make_random(3);
    run_stream(1'b0, 6);

    // randomized lengths with random gaps
    for (int r = 0; r < 8; r++) begin
      make_random($urandom_range(1, CAP));
      run_stream(1'b1, -1);
    end

    // reset mid-stream after 6 data bytes
    load_basic();
    build_model();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stream_q[i]);
    #2 rst = 1'b0;
    #1;
    check("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("midrst_waddr", waddr, 32'd0);
    check("midrst_wdata", wdata, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    base_we = we_cnt;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_we", 32'(we_cnt - base_we), 32'd0);
    check("midrst_done_after", {31'd0, done}, 32'd0);
    load_basic();
    run_stream(1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
